// File: rtl/ring_dec.sv
// ring_dec -- ring / Johnson counter sequence decoder and tracker.
//
// Watches an 8-bit counter pattern, sampled whenever en=1, and reports its
// decoded position, whether it belongs to the selected sequence, and whether
// the stream of samples has locked onto that sequence. Once locked, any
// sample that is not the successor of the previous one raises a one-cycle
// err pulse and bumps a saturating error counter.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous reset, active low
//   ring     in   1  mode: 1 = ring (rotate), 0 = Johnson (twisted ring)
//   en       in   1  sample strobe; count_in is valid when high
//   count_in in   8  counter pattern under observation
//   idx      out  4  decoded sequence position (registered)
//   legal    out  1  last sample belongs to the selected sequence (registered)
//   locked   out  1  tracker is in the LOCKED state
//   err      out  1  one-cycle pulse on a violation while locked
//   err_cnt  out  8  violation count, saturates at 0xFF
module ring_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       ring,
  input  logic       en,
  input  logic [7:0] count_in,
  output logic [3:0] idx,
  output logic       legal,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] mc_q, mc_d;        // consecutive successor matches seen in TRACK
  logic [7:0] prev_q, prev_d;    // previous sample, also the ring reference
  logic       mode_q, mode_d;    // mode the previous sample was taken in

  logic [3:0] idx_d;
  logic       legal_d;
  logic       err_d;
  logic [7:0] err_cnt_d;

  // Sample decode
  logic [7:0] j_succ;
  logic [7:0] r_succ;
  logic [7:0] plus_one;
  logic [7:0] inv_plus_one;
  logic [3:0] pop;
  logic       j_legal;
  logic [3:0] j_idx;
  logic       s_legal;
  logic       match;
  logic       first;
  logic       viol;

  // NOTE: every signal driven in always_comb gets a default on entry so that
  // no path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    j_succ       = {prev_q[6:0], ~prev_q[7]};
    r_succ       = {prev_q[6:0], prev_q[7]};
    plus_one     = count_in + 8'd1;
    inv_plus_one = ~count_in + 8'd1;
    pop          = 4'($countones(count_in));

    // Johnson members are either a run of ones from bit 0 (0x00..0xFF) or a
    // run of ones ending at bit 7 (0xFE..0x80): x & (x+1) == 0 detects the
    // first form, the same test on ~x detects the second.
    j_legal = ((count_in & plus_one) == 8'h00) ||
              ((~count_in & inv_plus_one) == 8'h00);

    // Rising half counts ones; falling half is 16 - popcount, which in four
    // bits is simply the two's complement of popcount.
    if (count_in[0] || (count_in == 8'h00)) begin
      j_idx = pop;
    end else begin
      j_idx = 4'd0 - pop;
    end

    s_legal = ring ? (count_in != 8'h00) : j_legal;
    match   = s_legal && (count_in == (ring ? r_succ : j_succ));

    // A mode change restarts tracking exactly as if coming out of IDLE.
    first = (state_q == IDLE) || (ring != mode_q);
    viol  = en && !first && (state_q == LOCKED) && !match;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    prev_d  = prev_q;
    mode_d  = mode_q;

    if (en) begin
      prev_d = count_in;
      mode_d = ring;
      if (first) begin
        state_d = s_legal ? TRACK : IDLE;
        mc_d    = 2'd0;
      end else if (state_q == TRACK) begin
        if (match) begin
          if (mc_q == 2'd3) begin
            state_d = LOCKED;
            mc_d    = 2'd0;
          end else begin
            mc_d = mc_q + 2'd1;
          end
        end else begin
          mc_d = 2'd0;
        end
      end else if (!match) begin
        state_d = TRACK;
        mc_d    = 2'd0;
      end
    end
  end

  // Output logic (values for the output registers)
  always_comb begin
    idx_d     = idx;
    legal_d   = legal;
    err_d     = 1'b0;
    err_cnt_d = err_cnt;

    if (en) begin
      legal_d = s_legal;
      err_d   = viol;
      if (viol && (err_cnt != 8'hFF)) begin
        err_cnt_d = err_cnt + 8'd1;
      end

      if (!s_legal) begin
        idx_d = 4'd0;
      end else if (ring) begin
        // Ring position is rotations since the reference; any break in the
        // successor chain makes the current sample the new reference.
        idx_d = (!first && match) ? {1'b0, idx[2:0] + 3'd1} : 4'd0;
      end else begin
        idx_d = j_idx;
      end
    end
  end

  // State and output registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mc_q    <= 2'd0;
      prev_q  <= 8'h00;
      mode_q  <= 1'b0;
      idx     <= 4'd0;
      legal   <= 1'b0;
      err     <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      prev_q  <= prev_d;
      mode_q  <= mode_d;
      idx     <= idx_d;
      legal   <= legal_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_ring_dec.sv
// tb_ring_dec -- self-checking bench for ring_dec.
// A directed table of {inputs, expected outputs}, a few hand-written
// multi-cycle sequences (illegal-from-IDLE, saturation, async reset), and a
// biased random run checked against a behavioural model built on the
// listed Johnson sequence and plain rotate arithmetic.
module tb_ring_dec;

  logic       clk;
  logic       rst;
  logic       ring;
  logic       en;
  logic [7:0] count_in;
  logic [3:0] idx;
  logic       legal;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  ring_dec dut (
    .clk      (clk),
    .rst      (rst),
    .ring     (ring),
    .en       (en),
    .count_in (count_in),
    .idx      (idx),
    .legal    (legal),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int e_idx, input int e_legal,
                           input int e_locked, input int e_err, input int e_cnt);
    check({tag, ".idx"},     32'(idx),     32'(e_idx));
    check({tag, ".legal"},   32'(legal),   32'(e_legal));
    check({tag, ".locked"},  32'(locked),  32'(e_locked));
    check({tag, ".err"},     32'(err),     32'(e_err));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  // Drive one sample, let the edge take it, look at outputs 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    ring     = r;
    en       = e;
    count_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en  = 1'b0;
    ring = 1'b0;
    count_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int jseq[16];                 // the 16 Johnson patterns in sequence order
  int m_state, m_mc, m_prev, m_mode, m_rot, m_cnt;
  int m_idx, m_legal, m_err;

  function automatic int jpos(input int v);
    for (int i = 0; i < 16; i++) if (jseq[i] == v) return i;
    return -1;
  endfunction

  function automatic int rotl(input int v);
    return ((v << 1) | (v >> 7)) & 255;
  endfunction

  task automatic model_reset();
    m_state = 0; m_mc = 0; m_prev = 0; m_mode = 0; m_rot = 0; m_cnt = 0;
    m_idx = 0; m_legal = 0; m_err = 0;
  endtask

  task automatic model_step(input int r, input int e, input int d);
    int  lg;
    int  ok;
    int  fst;
    m_err = 0;
    if (e == 0) return;
    lg = (r != 0) ? (d != 0) : (jpos(d) >= 0);
    if (r != 0) ok = lg && (d == rotl(m_prev));
    else        ok = lg && (jpos(m_prev) >= 0) && (d == jseq[(jpos(m_prev) + 1) % 16]);
    fst = (m_state == 0) || (r != m_mode);
    if (fst) begin
      m_state = lg ? 1 : 0;
      m_mc = 0;
      m_rot = 0;
    end else if (m_state == 1) begin
      if (ok) begin
        m_mc++;
        m_rot = (m_rot + 1) % 8;
        if (m_mc == 4) begin m_state = 2; m_mc = 0; end
      end else begin
        m_mc = 0;
        m_rot = 0;
      end
    end else begin
      if (ok) m_rot = (m_rot + 1) % 8;
      else begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
        m_state = 1;
        m_mc = 0;
        m_rot = 0;
      end
    end
    m_prev  = d;
    m_mode  = r;
    m_legal = lg;
    m_idx   = (lg == 0) ? 0 : ((r != 0) ? m_rot : jpos(d));
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic       ring;
    logic       en;
    logic [7:0] din;
    logic [3:0] idx;
    logic       legal;
    logic       locked;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  localparam int NT = 31;
  vec_t tbl[NT];

  initial begin
    int pos;
    int exp_cnt;
    int last;
    int r;
    int c;
    logic e;
    logic [7:0] d;

    for (int i = 0; i < 9; i++) jseq[i] = (1 << i) - 1;
    for (int i = 9; i < 16; i++) jseq[i] = (255 << (i - 8)) & 255;

    //          ring  en    din    idx  legal lock  err   cnt
    tbl[0]  = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 8'h03, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b1, 8'h07, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 8'h0F, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0};  // Johnson lock
    tbl[5]  = '{1'b0, 1'b1, 8'h3F, 4'd6, 1'b1, 1'b0, 1'b1, 8'd1};  // violation
    tbl[6]  = '{1'b0, 1'b0, 8'h7F, 4'd6, 1'b1, 1'b0, 1'b0, 8'd1};  // en=0 holds, err drops
    tbl[7]  = '{1'b0, 1'b1, 8'h7F, 4'd7, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b0, 1'b1, 8'h05, 4'd0, 1'b0, 1'b0, 1'b0, 8'd1};  // illegal in TRACK
    tbl[9]  = '{1'b1, 1'b1, 8'h03, 4'd0, 1'b1, 1'b0, 1'b0, 8'd1};  // mode change to ring
    tbl[10] = '{1'b1, 1'b1, 8'h06, 4'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 1'b1, 8'h0C, 4'd2, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 1'b1, 8'h18, 4'd3, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 1'b1, 8'h30, 4'd4, 1'b1, 1'b1, 1'b0, 8'd1};  // locked after 5th
    tbl[14] = '{1'b1, 1'b1, 8'h60, 4'd5, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1'b1, 1'b1, 8'hC0, 4'd6, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[16] = '{1'b1, 1'b1, 8'h81, 4'd7, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[17] = '{1'b1, 1'b1, 8'h03, 4'd0, 1'b1, 1'b1, 1'b0, 8'd1};  // ring wrap 7->0
    tbl[18] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 8'd1};  // mode switch while locked
    tbl[19] = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[20] = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 8'd1};  // repeat in TRACK, no err
    tbl[21] = '{1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd1};  // ring 0x00 illegal
    tbl[22] = '{1'b1, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[23] = '{1'b0, 1'b1, 8'hF8, 4'd11, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[24] = '{1'b0, 1'b1, 8'hF0, 4'd12, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[25] = '{1'b0, 1'b1, 8'hE0, 4'd13, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[26] = '{1'b0, 1'b1, 8'hC0, 4'd14, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[27] = '{1'b0, 1'b1, 8'h80, 4'd15, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[28] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 8'd1};  // Johnson wrap 15->0
    tbl[29] = '{1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[30] = '{1'b0, 1'b1, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b1, 8'd2};  // skip ahead while locked

    ring = 1'b0; en = 1'b0; count_in = 8'h00; rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    do_reset();
    check_all("after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < NT; i++) begin
      step(tbl[i].ring, tbl[i].en, tbl[i].din);
      check_all($sformatf("tbl[%0d]", i), int'(tbl[i].idx), int'(tbl[i].legal),
                int'(tbl[i].locked), int'(tbl[i].err), int'(tbl[i].cnt));
    end

    // Illegal Johnson pattern straight out of reset: stays IDLE, no err.
    do_reset();
    step(1'b0, 1'b1, 8'h05);
    check_all("idle_illegal", 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 8'h05);
    check_all("idle_illegal2", 0, 0, 0, 0, 0);

    // Biased random run against the model.
    do_reset();
    model_reset();
    last = 0;
    r = 0;
    for (int i = 0; i < 3000; i++) begin
      c = int'($urandom_range(0, 99));
      if (c >= 96) r = 1 - r;
      if (c < 75) begin
        if (r != 0) d = (last == 0) ? 8'($urandom_range(1, 255)) : 8'(rotl(last));
        else        d = (jpos(last) >= 0) ? 8'(jseq[(jpos(last) + 1) % 16])
                                          : 8'(jseq[$urandom_range(0, 15)]);
      end else if (c < 85) d = 8'($urandom_range(0, 255));
      else if (c < 90)     d = 8'(last);
      else                 d = 8'(jseq[$urandom_range(0, 15)]);
      e = ($urandom_range(0, 9) != 0);
      step(r[0], e, d);
      model_step(r, int'(e), int'(d));
      if (e) last = int'(d);
      check_all($sformatf("rand[%0d]", i), m_idx, m_legal, m_state == 2 ? 1 : 0, m_err, m_cnt);
    end

    // Saturation: 300 violations, relocking in between.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(jseq[i]));
    check("sat_lock", 32'(locked), 32'd1);
    pos = 4;
    exp_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 1'b1, 8'(jseq[pos]));          // repeated pattern = violation
      if (exp_cnt < 255) exp_cnt++;
      check("sat_err", 32'(err), 32'd1);
      check("sat_cnt", 32'(err_cnt), 32'(exp_cnt));
      for (int j = 0; j < 4; j++) begin
        pos = (pos + 1) % 16;
        step(1'b0, 1'b1, 8'(jseq[pos]));
      end
      check("sat_relock", 32'(locked), 32'd1);
    end
    check_all("sat_final", jpos(jseq[pos]), 1, 1, 0, 255);

    // Asynchronous reset mid-cycle while locked.
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    en = 1'b1;
    count_in = 8'h01;
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h01);
    check_all("post_rst_first", 1, 1, 0, 0, 0);
    step(1'b0, 1'b1, 8'h03);
    check_all("post_rst_second", 2, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
